// File: rtl/dff_pipe_chain.sv
// WIDTH x DEPTH register pipeline with per-stage valid, valid/ready backpressure, flush and occupancy count.
// Define PIPE_CHAIN_BUBBLE_COLLAPSE_EN for per-stage advance (bubbles fill under a stall); default is a global stall.
module dff_pipe_chain #(
    parameter int unsigned      WIDTH       = 8,
    parameter int unsigned      DEPTH       = 4,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0,
    parameter int unsigned      DELAY       = 1
) (
    input  logic                         iClock,
    input  logic                         iReset,
    input  logic                         iValid,
    output logic                         oReady,
    input  logic [WIDTH-1:0]             iData,
    input  logic                         iFlush,
    output logic                         oValid,
    input  logic                         iReady,
    output logic [WIDTH-1:0]             oData,
    output logic [$clog2(DEPTH+1)-1:0]   oCount
);

    localparam int unsigned CW = $clog2(DEPTH + 1);

    // DELAY only shaped the old behavioural model; synthesizable state updates carry no delay.
    if (DELAY > 32'd1_000_000) begin : gDelayUnused
    end

    logic [DEPTH-1:0] valid;
    logic [DEPTH-1:0] validNext;
    logic [DEPTH-1:0] advance;
    logic [DEPTH-1:0] upValid;
    logic [DEPTH-1:0] load;
    logic [WIDTH-1:0] data   [DEPTH];
    logic [WIDTH-1:0] upData [DEPTH];
    logic [CW-1:0]    count;
    logic [CW-1:0]    countNext;
    logic             transferIn;

    always_comb begin
        advance = '0;
        advance[DEPTH-1] = iReady | ~valid[DEPTH-1];
`ifdef PIPE_CHAIN_BUBBLE_COLLAPSE_EN
        // Walk from the output towards the input so each stage sees its successor's enable.
        for (int unsigned j = 0; j + 1 < DEPTH; j++) begin
            advance[DEPTH-2-j] = advance[DEPTH-1-j] | ~valid[DEPTH-2-j];
        end
`else
        for (int unsigned k = 0; k + 1 < DEPTH; k++) begin
            advance[k] = advance[DEPTH-1];
        end
`endif
    end

    assign oReady     = advance[0] & ~iFlush & ~iReset;
    assign transferIn = iValid & oReady;

    always_comb begin
        upValid   = '0;
        upValid[0] = transferIn;
        upData[0]  = iData;
        for (int unsigned k = 1; k < DEPTH; k++) begin
            upValid[k] = valid[k-1];
            upData[k]  = data[k-1];
        end
        validNext = '0;
        load      = '0;
        countNext = '0;
        for (int unsigned k = 0; k < DEPTH; k++) begin
            validNext[k] = advance[k] ? upValid[k] : valid[k];
            load[k]      = advance[k] & upValid[k] & ~iFlush;
        end
        if (iFlush || iReset) begin
            validNext = '0;
        end
        for (int unsigned k = 0; k < DEPTH; k++) begin
            countNext = countNext + CW'(validNext[k]);
        end
    end

    always_ff @(posedge iClock) begin
        if (iReset) begin
            valid <= '0;
            count <= '0;
            for (int unsigned k = 0; k < DEPTH; k++) begin
                data[k] <= RESET_VALUE;
            end
        end else begin
            valid <= validNext;
            count <= countNext;
            for (int unsigned k = 0; k < DEPTH; k++) begin
                if (load[k]) begin
                    data[k] <= upData[k];
                end
            end
        end
    end

    assign oValid = valid[DEPTH-1];
    assign oData  = data[DEPTH-1];
    assign oCount = count;

endmodule
